// File: rtl/acc_mc_ctrl_if.sv
// Request/acknowledge handshakes between the sequencer and the
// instruction and data memories.
interface acc_mc_ctrl_if;
    logic ins_req;
    logic ins_ack;
    logic data_req;
    logic data_we;
    logic data_ack;

    modport master (output ins_req, data_req, data_we, input ins_ack, data_ack);
    modport slave  (input ins_req, data_req, data_we, output ins_ack, data_ack);
endinterface

// File: rtl/acc_mc_ctrl.sv
// Multi-cycle sequencer for the 16-bit accumulator CPU: fetch, decode, memory
// access and execute, with memory handshakes, single-step and a wait timeout.
module acc_mc_ctrl #(
    parameter int TMO_W   = 4,
    parameter int TMO_MAX = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 step_mode,
    input  logic [3:0]           ir_op,
    input  logic                 zero,
    acc_mc_ctrl_if.master        memBus,
    output logic                 ir_ld,
    output logic                 pc_inc,
    output logic                 pc_ld,
    output logic                 acc_wr,
    output logic [3:0]           alu_op,
    output logic                 halted,
    output logic                 fault,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        MEM    = 3'd3,
        EXEC   = 3'd4,
        HALT   = 3'd5,
        FAULT  = 3'd6
    } stateType;

    localparam logic [3:0] OP_HALT  = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_NOT   = 4'h7;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_JZ    = 4'h9;

    localparam logic [TMO_W-1:0] WAIT_LIMIT = TMO_W'(TMO_MAX);

    stateType         state;
    stateType         afterEnd;
    logic [TMO_W-1:0] waitCnt;
    logic             needsMem;
    logic             waitExpired;

    // "END" of an instruction: park in IDLE when single-stepping, else fetch on.
    assign afterEnd    = step_mode ? IDLE : FETCH;
    assign needsMem    = ir_op inside {[OP_LOAD:OP_OR]};
    assign waitExpired = (waitCnt == WAIT_LIMIT);

    // NOTE: state and counter are updated only with non-blocking assignments so
    // every branch below reads the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            waitCnt <= '0;
        end else begin
            waitCnt <= '0;
            case (state)
                IDLE: if (run) state <= FETCH;

                FETCH: begin
                    // An ack in the limit cycle still wins over the timeout.
                    if (memBus.ins_ack)   state   <= DECODE;
                    else if (waitExpired) state   <= FAULT;
                    else                  waitCnt <= waitCnt + 1'b1;
                end

                DECODE: begin
                    if (ir_op == OP_HALT)     state <= HALT;
                    else if (needsMem)        state <= MEM;
                    else if (ir_op == OP_NOT) state <= EXEC;
                    else                      state <= afterEnd;
                end

                MEM: begin
                    if (memBus.data_ack)  state   <= (ir_op == OP_STORE) ? afterEnd : EXEC;
                    else if (waitExpired) state   <= FAULT;
                    else                  waitCnt <= waitCnt + 1'b1;
                end

                EXEC: state <= afterEnd;

                HALT, FAULT: state <= state;

                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        memBus.ins_req  = 1'b0;
        memBus.data_req = 1'b0;
        memBus.data_we  = 1'b0;
        ir_ld           = 1'b0;
        pc_inc          = 1'b0;
        pc_ld           = 1'b0;
        acc_wr          = 1'b0;
        alu_op          = 4'h0;
        halted          = 1'b0;
        fault           = 1'b0;
        state_dbg       = state;
        case (state)
            FETCH: begin
                memBus.ins_req = 1'b1;
                ir_ld          = memBus.ins_ack;
                pc_inc         = memBus.ins_ack;
            end
            DECODE: pc_ld = (ir_op == OP_JMP) || ((ir_op == OP_JZ) && zero);
            MEM: begin
                memBus.data_req = 1'b1;
                memBus.data_we  = (ir_op == OP_STORE);
            end
            EXEC: begin
                alu_op = ir_op;
                acc_wr = 1'b1;
            end
            HALT:    halted = 1'b1;
            FAULT:   fault  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_acc_mc_ctrl.sv
// Self-checking bench for acc_mc_ctrl: each instruction is expanded into its
// expected phase sequence (fetch/decode/mem/exec) and compared cycle by cycle.
module tb_acc_mc_ctrl;

    localparam int TMO_MAX = 15;

    typedef struct packed {
        logic       rstN;
        logic       run;
        logic       stepMode;
        logic       insAck;
        logic       dataAck;
        logic       zero;
        logic [3:0] op;
    } inVec_t;

    typedef struct packed {
        logic       insReq;
        logic       dataReq;
        logic       dataWe;
        logic       irLd;
        logic       pcInc;
        logic       pcLd;
        logic       accWr;
        logic [3:0] aluOp;
        logic       halted;
        logic       fault;
        logic [2:0] stateDbg;
    } outVec_t;

    typedef struct {
        inVec_t  stim;
        outVec_t exp;
        bit      chk;
    } cycle_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       stepMode = 1'b0;
    logic [3:0] irOp = 4'h0;
    logic       zero = 1'b0;
    logic       irLd, pcInc, pcLd, accWr, halted, fault;
    logic [3:0] aluOp;
    logic [2:0] stateDbg;

    int vectors = 0;
    int miscompares = 0;
    cycle_t plan[$];

    acc_mc_ctrl_if bus ();

    acc_mc_ctrl #(.TMO_W(4), .TMO_MAX(TMO_MAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .step_mode (stepMode),
        .ir_op     (irOp),
        .zero      (zero),
        .memBus    (bus),
        .ir_ld     (irLd),
        .pc_inc    (pcInc),
        .pc_ld     (pcLd),
        .acc_wr    (accWr),
        .alu_op    (aluOp),
        .halted    (halted),
        .fault     (fault),
        .state_dbg (stateDbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Expected outputs per phase, straight from the opcode/phase rules.
    function automatic outVec_t expIdle();
        outVec_t e = '0;
        return e;
    endfunction

    function automatic outVec_t expFetch(input logic last);
        outVec_t e = '0;
        e.insReq = 1'b1; e.irLd = last; e.pcInc = last; e.stateDbg = 3'd1;
        return e;
    endfunction

    function automatic outVec_t expDecode(input logic [3:0] op, input logic z);
        outVec_t e = '0;
        e.stateDbg = 3'd2;
        e.pcLd = (op == 4'h8) || ((op == 4'h9) && z);
        return e;
    endfunction

    function automatic outVec_t expMem(input logic [3:0] op);
        outVec_t e = '0;
        e.dataReq = 1'b1; e.dataWe = (op == 4'h2); e.stateDbg = 3'd3;
        return e;
    endfunction

    function automatic outVec_t expExec(input logic [3:0] op);
        outVec_t e = '0;
        e.aluOp = op; e.accWr = 1'b1; e.stateDbg = 3'd4;
        return e;
    endfunction

    function automatic outVec_t expHalt();
        outVec_t e = '0;
        e.halted = 1'b1; e.stateDbg = 3'd5;
        return e;
    endfunction

    function automatic outVec_t expFault();
        outVec_t e = '0;
        e.fault = 1'b1; e.stateDbg = 3'd6;
        return e;
    endfunction

    function automatic outVec_t sampleDut();
        outVec_t g;
        g.insReq = bus.ins_req; g.dataReq = bus.data_req; g.dataWe = bus.data_we;
        g.irLd = irLd; g.pcInc = pcInc; g.pcLd = pcLd; g.accWr = accWr;
        g.aluOp = aluOp; g.halted = halted; g.fault = fault; g.stateDbg = stateDbg;
        return g;
    endfunction

    task automatic addCycle(input logic rstN, input logic rn, input logic sm, input logic iAck,
                            input logic dAck, input logic z, input logic [3:0] op,
                            input outVec_t exp, input bit chk);
        cycle_t c;
        c.stim.rstN = rstN; c.stim.run = rn; c.stim.stepMode = sm;
        c.stim.insAck = iAck; c.stim.dataAck = dAck; c.stim.zero = z; c.stim.op = op;
        c.exp = exp;
        c.chk = chk;
        plan.push_back(c);
    endtask

    task automatic addReset();
        addCycle(1'b0, rb(), rb(), rb(), rb(), rb(), 4'($urandom), expIdle(), 1'b0);
    endtask

    task automatic addIdle(input logic rn);
        addCycle(1'b1, rn, rb(), rb(), rb(), rb(), 4'($urandom), expIdle(), 1'b1);
    endtask

    task automatic addHalt();
        addCycle(1'b1, rb(), rb(), rb(), rb(), rb(), 4'($urandom), expHalt(), 1'b1);
    endtask

    task automatic addFault();
        addCycle(1'b1, rb(), rb(), rb(), rb(), rb(), 4'($urandom), expFault(), 1'b1);
    endtask

    // One instruction starting in FETCH; acks arrive after the given wait cycles,
    // and acks to the memory not currently requested are thrown in at random.
    task automatic addInstr(input logic [3:0] op, input int insDelay, input int dataDelay,
                            input logic zDec, input logic sm, input logic rn);
        logic last;
        for (int w = 0; w <= insDelay; w++) begin
            last = (w == insDelay);
            addCycle(1'b1, rn, sm, last, rb(), rb(), op, expFetch(last), 1'b1);
        end
        addCycle(1'b1, rn, sm, rb(), rb(), zDec, op, expDecode(op, zDec), 1'b1);
        if (op inside {[4'd1:4'd6]}) begin
            for (int w = 0; w <= dataDelay; w++) begin
                last = (w == dataDelay);
                addCycle(1'b1, rn, sm, rb(), last, rb(), op, expMem(op), 1'b1);
            end
        end
        if (op inside {4'd1, [4'd3:4'd7]})
            addCycle(1'b1, rn, sm, rb(), rb(), rb(), op, expExec(op), 1'b1);
    endtask

    task automatic tick(input inVec_t s);
        @(negedge clk);
        reset        = s.rstN;
        run          = s.run;
        stepMode     = s.stepMode;
        bus.ins_ack  = s.insAck;
        bus.data_ack = s.dataAck;
        zero         = s.zero;
        irOp         = s.op;
        #1;
    endtask

    task automatic test_reset();
        outVec_t got;
        plan.delete();
        addReset();
        for (int i = 0; i < 3; i++)
            addCycle(1'b0, 1'b1, rb(), rb(), rb(), rb(), 4'($urandom), expIdle(), 1'b1);
        addIdle(1'b0);
        foreach (plan[i]) begin
            tick(plan[i].stim);
            got = sampleDut();
            if (plan[i].chk) begin
                vectors++;
                if (got !== plan[i].exp) begin
                    miscompares++;
                    $display("FAIL test_reset cycle %0d: got %b expected %b", i, got, plan[i].exp);
                end
            end
        end
    endtask

    task automatic test_program();
        outVec_t got;
        int accCnt = 0, weCnt = 0, firstHalt = -1;
        plan.delete();
        addReset();
        addIdle(1'b1);
        addInstr(4'h1, 0, 0, rb(), 1'b0, 1'b1);
        addInstr(4'h3, 0, 0, rb(), 1'b0, 1'b1);
        addInstr(4'h2, 0, 0, rb(), 1'b0, 1'b1);
        addInstr(4'h0, 0, 0, rb(), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) addHalt();
        foreach (plan[i]) begin
            tick(plan[i].stim);
            got = sampleDut();
            accCnt += int'(got.accWr);
            weCnt  += int'(got.dataWe);
            if (got.halted === 1'b1 && firstHalt < 0) firstHalt = i - 1;
            if (plan[i].chk) begin
                vectors++;
                if (got !== plan[i].exp) begin
                    miscompares++;
                    $display("FAIL test_program cycle %0d: got %b expected %b", i, got, plan[i].exp);
                end
            end
        end
        vectors++;
        if (accCnt !== 2) begin
            miscompares++;
            $display("FAIL program_acc_wr_pulses: got %0d expected 2", accCnt);
        end
        vectors++;
        if (weCnt !== 1) begin
            miscompares++;
            $display("FAIL program_data_we_cycles: got %0d expected 1", weCnt);
        end
        vectors++;
        if (firstHalt !== 14) begin
            miscompares++;
            $display("FAIL program_halt_cycle: got %0d expected 14", firstHalt);
        end
    endtask

    task automatic test_jz();
        outVec_t got;
        plan.delete();
        addReset();
        addIdle(1'b1);
        addInstr(4'h9, 0, 0, 1'b1, 1'b0, 1'b1);
        addInstr(4'h9, 0, 0, 1'b0, 1'b0, 1'b1);
        addInstr(4'h8, 1, 0, 1'b0, 1'b0, 1'b0);
        addInstr(4'hC, 0, 0, 1'b1, 1'b1, 1'b0);
        addIdle(1'b0);
        foreach (plan[i]) begin
            tick(plan[i].stim);
            got = sampleDut();
            if (plan[i].chk) begin
                vectors++;
                if (got !== plan[i].exp) begin
                    miscompares++;
                    $display("FAIL test_jz cycle %0d: got %b expected %b", i, got, plan[i].exp);
                end
            end
        end
    endtask

    task automatic test_ins_delay();
        outVec_t got;
        int reqCnt = 0, ldCnt = 0;
        plan.delete();
        addReset();
        addIdle(1'b1);
        addInstr(4'h7, 3, 0, rb(), 1'b1, 1'b0);
        addIdle(1'b0);
        addIdle(1'b0);
        foreach (plan[i]) begin
            tick(plan[i].stim);
            got = sampleDut();
            reqCnt += int'(got.insReq);
            ldCnt  += int'(got.irLd && got.pcInc);
            if (plan[i].chk) begin
                vectors++;
                if (got !== plan[i].exp) begin
                    miscompares++;
                    $display("FAIL test_ins_delay cycle %0d: got %b expected %b", i, got, plan[i].exp);
                end
            end
        end
        vectors++;
        if (reqCnt !== 4 || ldCnt !== 1) begin
            miscompares++;
            $display("FAIL ins_delay_counts: got req=%0d ld=%0d expected req=4 ld=1", reqCnt, ldCnt);
        end
    endtask

    task automatic test_timeout();
        outVec_t got;
        plan.delete();
        addReset();
        addIdle(1'b1);
        // Acks landing exactly in the limit cycle must still be accepted.
        addInstr(4'h1, TMO_MAX, TMO_MAX, rb(), 1'b0, 1'b1);
        addCycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, rb(), 4'h2, expFetch(1'b1), 1'b1);
        addCycle(1'b1, 1'b1, 1'b0, rb(), 1'b0, 1'b0, 4'h2, expDecode(4'h2, 1'b0), 1'b1);
        for (int w = 0; w <= TMO_MAX; w++)
            addCycle(1'b1, rb(), 1'b0, rb(), 1'b0, rb(), 4'h2, expMem(4'h2), 1'b1);
        for (int i = 0; i < 4; i++) addFault();
        addCycle(1'b0, 1'b1, 1'b0, rb(), rb(), rb(), 4'h2, expFault(), 1'b1);
        addIdle(1'b1);
        for (int w = 0; w <= TMO_MAX; w++)
            addCycle(1'b1, rb(), rb(), 1'b0, rb(), rb(), 4'($urandom), expFetch(1'b0), 1'b1);
        addFault();
        addFault();
        foreach (plan[i]) begin
            tick(plan[i].stim);
            got = sampleDut();
            if (plan[i].chk) begin
                vectors++;
                if (got !== plan[i].exp) begin
                    miscompares++;
                    $display("FAIL test_timeout cycle %0d: got %b expected %b", i, got, plan[i].exp);
                end
            end
        end
    endtask

    task automatic test_step();
        outVec_t got;
        plan.delete();
        addReset();
        addIdle(1'b1);
        addInstr(4'h3, 1, 2, rb(), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) addIdle(1'b0);
        addIdle(1'b1);
        addInstr(4'h2, 0, 0, rb(), 1'b1, 1'b0);
        addIdle(1'b0);
        foreach (plan[i]) begin
            tick(plan[i].stim);
            got = sampleDut();
            if (plan[i].chk) begin
                vectors++;
                if (got !== plan[i].exp) begin
                    miscompares++;
                    $display("FAIL test_step cycle %0d: got %b expected %b", i, got, plan[i].exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        outVec_t got;
        plan.delete();
        addReset();
        addIdle(1'b1);
        addCycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, rb(), 4'h1, expFetch(1'b1), 1'b1);
        addCycle(1'b1, 1'b1, 1'b0, rb(), 1'b0, 1'b0, 4'h1, expDecode(4'h1, 1'b0), 1'b1);
        for (int i = 0; i < 3; i++)
            addCycle(1'b1, 1'b1, 1'b0, rb(), 1'b0, rb(), 4'h1, expMem(4'h1), 1'b1);
        // The request is still visible in the reset cycle and drops on the next.
        addCycle(1'b0, 1'b1, 1'b0, rb(), 1'b0, rb(), 4'h1, expMem(4'h1), 1'b1);
        addCycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, rb(), 4'h1, expIdle(), 1'b1);
        addInstr(4'hA, 2, 0, rb(), 1'b1, 1'b1);
        addIdle(1'b0);
        foreach (plan[i]) begin
            tick(plan[i].stim);
            got = sampleDut();
            if (plan[i].chk) begin
                vectors++;
                if (got !== plan[i].exp) begin
                    miscompares++;
                    $display("FAIL test_reset_mid_mem cycle %0d: got %b expected %b", i, got, plan[i].exp);
                end
            end
        end
    endtask

    task automatic test_random();
        outVec_t    got;
        logic [3:0] op;
        logic       sm;
        plan.delete();
        addReset();
        addIdle(1'b1);
        for (int n = 0; n < 40; n++) begin
            op = 4'(1 + $urandom_range(0, 14));
            sm = ($urandom_range(0, 3) == 0);
            addInstr(op, $urandom_range(0, 3), $urandom_range(0, 3), rb(), sm, rb());
            if (sm) begin
                for (int k = 0; k < int'($urandom_range(0, 2)); k++) addIdle(1'b0);
                addIdle(1'b1);
            end
        end
        addInstr(4'h0, $urandom_range(0, 3), 0, rb(), rb(), rb());
        for (int i = 0; i < 3; i++) addHalt();
        foreach (plan[i]) begin
            tick(plan[i].stim);
            got = sampleDut();
            if (plan[i].chk) begin
                vectors++;
                if (got !== plan[i].exp) begin
                    miscompares++;
                    $display("FAIL test_random cycle %0d op %h: got %b expected %b",
                             i, plan[i].stim.op, got, plan[i].exp);
                end
            end
        end
    endtask

    initial begin
        bus.ins_ack  = 1'b0;
        bus.data_ack = 1'b0;
        test_reset();
        test_program();
        test_jz();
        test_ins_delay();
        test_timeout();
        test_step();
        test_reset_mid_mem();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/acc_mc_ctrl.md
Name: acc_mc_ctrl

Overview:
- Multi-cycle sequencer for the 16-bit accumulator CPU datapath (PC, instruction memory, ACC, ALU, data memory).
- Replaces single-cycle opcode decode with an FSM: fetch, decode, memory access, execute.
- Adds req/ack handshakes to both memories, single-step debug and a handshake timeout fault.
- Drives PC/IR/ACC strobes and the 4-bit ALU op.

Parameters:
- TMO_W, 4, width of handshake wait counter.
- TMO_MAX, 15, cycles waiting for an ack before entering FAULT; must be ≤ 2^TMO_W-1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- run  in  1  level; leave IDLE and start/continue execution
- step_mode  in  1  1 = return to IDLE after each completed instruction
- ir_op  in  4  opcode field of IR (IR[15:12])
- zero  in  1  ALU conditional flag (ACC == 0)
- ins_req  out  1  instruction memory request, address = PC
- ins_ack  in  1  instruction word valid this cycle
- data_req  out  1  data memory request, address = IR[11:0]
- data_we  out  1  write qualifier with data_req (STORE)
- data_ack  in  1  data read valid / write done this cycle
- ir_ld  out  1  load IR from instruction memory
- pc_inc  out  1  PC <= PC+1 (12-bit wrap)
- pc_ld  out  1  PC <= IR[11:0]; overrides pc_inc
- acc_wr  out  1  ACC <= ALU result
- alu_op  out  4  ALU operation; equals ir_op in EXEC, else 0000
- halted  out  1  in HALT
- fault  out  1  in FAULT
- state_dbg  out  3  current state encoding

Behaviour:
- Opcodes: 0000 HALT, 0001 LOAD, 0010 STORE, 0011 ADD, 0100 SUB, 0101 AND, 0110 OR, 0111 NOT, 1000 JMP, 1001 JZ, 1010-1111 NOP.
- State register is the only state plus the wait counter. Outputs are decoded from state, ir_op, ack and zero (Moore, except strobes that are gated by an ack).
- States: IDLE=0, FETCH=1, DECODE=2, MEM=3, EXEC=4, HALT=5, FAULT=6.
- Reset (reset==0 at clk edge): state=IDLE, counter=0. All outputs 0, state_dbg=0. Reset wins over every other input, including mid-handshake; an outstanding req drops the following cycle.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH:
  - ins_req=1.
  - When ins_ack=1: ir_ld=1 and pc_inc=1 in the same cycle, then -> DECODE.
  - Otherwise the counter increments; at counter==TMO_MAX with no ack -> FAULT.
  - Counter clears on every state change.
- DECODE (1 cycle):
  - HALT -> HALT.
  - JMP: pc_ld=1, then -> END.
  - JZ: pc_ld=zero, then -> END.
  - LOAD, STORE, ADD, SUB, AND, OR -> MEM.
  - NOT -> EXEC.
  - NOP -> END.
- MEM:
  - data_req=1, data_we=(op==STORE); hold both until data_ack, with the same timeout rule as FETCH.
  - On ack: STORE -> END; all others -> EXEC.
- EXEC (1 cycle): alu_op=ir_op, acc_wr=1, then -> END.
- END is not a separate state; it means the next state is IDLE if step_mode=1, else FETCH.
- HALT: halted=1; exits only via reset.
- FAULT: fault=1; all strobes 0; exits only via reset.
- ack while no req is asserted: ignored.
- ack and counter==TMO_MAX in the same cycle: the ack wins.
- run dropping mid-instruction: the instruction completes; the FSM then goes to FETCH or IDLE per step_mode, and IDLE holds while run=0.
- Latency with zero-wait acks:
  - ALU/LOAD: 4 cycles (FETCH, DECODE, MEM, EXEC).
  - STORE: 3 cycles.
  - NOT: 3 cycles.
  - JMP/JZ/NOP: 2 cycles.
- At most one of pc_inc/pc_ld is active per cycle; acc_wr and data_we are never both 1.

Test Plan:
- Reset, run=1, program LOAD 5; ADD 6; STORE 7; HALT with ack in same cycle as req -> FETCH/DECODE/MEM/EXEC visits 4/4/3/2 cycles; acc_wr pulses twice, data_we one cycle; halted=1 in cycle 14 and stays.
- JZ 0x020 with zero=1 and then zero=0 -> pc_ld=1 in DECODE for the first; pc_inc only (from FETCH) for the second.
- ins_ack delayed 3 cycles -> ins_req held 4 cycles, ir_ld/pc_inc pulse exactly once on the ack cycle.
- data_ack never returns -> data_req high for 16 cycles, then fault=1 (state_dbg=6), all strobes 0.
- step_mode=1, run pulsed 1 cycle -> exactly one instruction executes, then state_dbg=0 until the next run.
- reset=0 asserted during MEM wait -> next cycle state_dbg=0 and all outputs 0; after release with run=1, fetch restarts.
